// File: rtl/cnn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : cnn_ctrl_pkg
// Brief   : Shared state encoding and default widths for CNN layer control.
// Rev     : 1.0  initial release
// ============================================================================
package cnn_ctrl_pkg;

    localparam int c_tile_w_default = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/tile_pipeline_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : tile_pipeline_scheduler_if
// Brief     : Layer-controller and load/compute/store unit signals of the scheduler.
// Rev       : 1.0  initial release
// ============================================================================
interface tile_pipeline_scheduler_if
    import cnn_ctrl_pkg::*;
#(
    parameter int TILE_W = c_tile_w_default
);
    logic              start;
    logic              abort;
    logic [TILE_W-1:0] num_tiles;
    logic              busy;
    logic              done;
    logic              buf_rotate;
    logic              ld_start;
    logic              ld_done;
    logic [TILE_W-1:0] ld_tile_idx;
    logic              cp_start;
    logic              cp_done;
    logic [TILE_W-1:0] cp_tile_idx;
    logic              st_start;
    logic              st_done;
    logic [TILE_W-1:0] st_tile_idx;

    // master: the scheduler itself
    modport master (
        input  start, abort, num_tiles, ld_done, cp_done, st_done,
        output busy, done, buf_rotate,
               ld_start, ld_tile_idx, cp_start, cp_tile_idx, st_start, st_tile_idx
    );

    modport slave (
        output start, abort, num_tiles, ld_done, cp_done, st_done,
        input  busy, done, buf_rotate,
               ld_start, ld_tile_idx, cp_start, cp_tile_idx, st_start, st_tile_idx
    );
endinterface
`default_nettype wire

// File: rtl/tile_pipeline_scheduler_unit_tracker.sv
`default_nettype none
// ============================================================================
// Module : unit_tracker
// Brief  : Per-unit start pulse and sticky done flag for one pipeline phase.
// Rev    : 1.0  initial release
// ============================================================================
module unit_tracker (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic i_clear,
    input  wire logic i_active,
    input  wire logic i_issue,
    input  wire logic i_done,
    output logic      o_start,
    output logic      o_satisfied
);
    logic r_active;
    logic r_flag;
    logic r_start;

    // A done seen while the start pulse is still out belongs to the ISSUE cycle and is dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_active <= 1'b0;
            r_flag   <= 1'b0;
            r_start  <= 1'b0;
        end else if (i_clear) begin
            r_active <= 1'b0;
            r_flag   <= 1'b0;
            r_start  <= 1'b0;
        end else if (i_issue) begin
            r_active <= i_active;
            r_start  <= i_active;
            r_flag   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (i_done && r_active && !r_start) begin
                r_flag <= 1'b1;
            end
        end
    end

    assign o_start     = r_start;
    assign o_satisfied = !r_active || r_flag;
endmodule
`default_nettype wire

// File: rtl/tile_pipeline_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tile_pipeline_scheduler
// Brief  : Load/compute/store tile pipeline sequencer over triple buffers.
// Rev    : 1.0  initial release
// ============================================================================
module tile_pipeline_scheduler
    import cnn_ctrl_pkg::*;
#(
    parameter int TILE_W = c_tile_w_default
) (
    input  wire logic               clk,
    input  wire logic               rstn,
    tile_pipeline_scheduler_if.master bus
);
    localparam logic [TILE_W:0]   c_phase_one = (TILE_W+1)'(1);
    localparam logic [TILE_W:0]   c_phase_two = (TILE_W+1)'(2);
    localparam logic [TILE_W-1:0] c_idx_one   = TILE_W'(1);
    localparam logic [TILE_W-1:0] c_idx_two   = TILE_W'(2);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [TILE_W:0]   r_phase;
    logic [TILE_W:0]   w_phase_nxt;
    logic [TILE_W-1:0] r_num_tiles;
    logic [TILE_W-1:0] w_num_nxt;
    logic [TILE_W:0]   w_n_ext;
    logic [TILE_W-1:0] w_phase_lo;
    logic              w_last;
    logic              w_all_sat;
    logic              w_issue;
    logic              w_clear;
    logic              w_ld_act, w_cp_act, w_st_act;
    logic              w_ld_sat, w_cp_sat, w_st_sat;
    logic              w_ld_start, w_cp_start, w_st_start;
    logic              r_busy;
    logic              r_done;
    logic              r_rotate;
    logic [TILE_W-1:0] r_ld_idx, r_cp_idx, r_st_idx;

    assign w_last    = (r_phase == ({1'b0, r_num_tiles} + c_phase_one));
    assign w_all_sat = w_ld_sat && w_cp_sat && w_st_sat;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_num_nxt   = r_num_tiles;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_num_nxt   = bus.num_tiles;
                    w_phase_nxt = '0;
                    w_state_nxt = (bus.num_tiles == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_all_sat) begin
                    if (w_last) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_phase_nxt = r_phase + c_phase_one;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = '0;
        end
    end

    // Unit activity is decided for the phase about to be issued, so pulses land in the ISSUE cycle
    assign w_n_ext    = {1'b0, w_num_nxt};
    assign w_phase_lo = w_phase_nxt[TILE_W-1:0];
    assign w_ld_act   = (w_phase_nxt < w_n_ext);
    assign w_cp_act   = (w_phase_nxt >= c_phase_one) && (w_phase_nxt <= w_n_ext);
    assign w_st_act   = (w_phase_nxt >= c_phase_two) && (w_phase_nxt <= (w_n_ext + c_phase_one));
    assign w_issue    = (w_state_nxt == S_ISSUE);
    assign w_clear    = bus.abort || (r_state == S_FINISH);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_num_tiles <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rotate    <= 1'b0;
            r_ld_idx    <= '0;
            r_cp_idx    <= '0;
            r_st_idx    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_num_tiles <= w_num_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (r_state == S_FINISH) && !bus.abort;
            r_rotate    <= w_issue;
            if (w_issue) begin
                r_ld_idx <= w_phase_lo;
                r_cp_idx <= w_phase_lo - c_idx_one;
                r_st_idx <= w_phase_lo - c_idx_two;
            end
        end
    end

    unit_tracker u_ld (
        .clk        (clk),
        .rstn       (rstn),
        .i_clear    (w_clear),
        .i_active   (w_ld_act),
        .i_issue    (w_issue),
        .i_done     (bus.ld_done),
        .o_start    (w_ld_start),
        .o_satisfied(w_ld_sat)
    );

    unit_tracker u_cp (
        .clk        (clk),
        .rstn       (rstn),
        .i_clear    (w_clear),
        .i_active   (w_cp_act),
        .i_issue    (w_issue),
        .i_done     (bus.cp_done),
        .o_start    (w_cp_start),
        .o_satisfied(w_cp_sat)
    );

    unit_tracker u_st (
        .clk        (clk),
        .rstn       (rstn),
        .i_clear    (w_clear),
        .i_active   (w_st_act),
        .i_issue    (w_issue),
        .i_done     (bus.st_done),
        .o_start    (w_st_start),
        .o_satisfied(w_st_sat)
    );

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.buf_rotate  = r_rotate;
    assign bus.ld_start    = w_ld_start;
    assign bus.cp_start    = w_cp_start;
    assign bus.st_start    = w_st_start;
    assign bus.ld_tile_idx = r_ld_idx;
    assign bus.cp_tile_idx = r_cp_idx;
    assign bus.st_tile_idx = r_st_idx;
endmodule
`default_nettype wire

// File: tb/tb_tile_pipeline_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_tile_pipeline_scheduler
// Brief  : Directed bench with a phase/timing reference model for the tile scheduler.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tile_pipeline_scheduler;
    localparam int TILE_W = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    tile_pipeline_scheduler_if #(.TILE_W(TILE_W)) ifc ();
    tile_pipeline_scheduler #(.TILE_W(TILE_W)) dut (.clk(clk), .rstn(rstn), .bus(ifc));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    bit chk_en = 1'b0, resp_en = 1'b0;
    int ld_lat = 4, cp_lat = 4, st_lat = 4, cp_extra = 0;
    int cnt_rot = 0, cnt_ld = 0, cnt_cp = 0, cnt_st = 0, cnt_done = 0, cnt_busy = 0;
    int last_done_cyc = 0;
    int ld_q[$], cp_q[$], st_q[$];

    // reference model: layer timeline in absolute cycle numbers
    int m_N = 0, m_phase = 0, m_rot_cyc = -1, m_done_cyc = -1;
    int m_busy_from = 1, m_busy_to = 0;
    bit m_wait = 1'b0, m_need_ld, m_need_cp, m_need_st;
    bit e_busy, e_rot, e_la, e_ca, e_sa;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            e_busy = (cyc >= m_busy_from) && (cyc <= m_busy_to);
            e_rot  = (cyc == m_rot_cyc);
            e_la   = e_rot && (m_phase < m_N);
            e_ca   = e_rot && (m_phase >= 1) && (m_phase <= m_N);
            e_sa   = e_rot && (m_phase >= 2) && (m_phase <= m_N + 1);
            chk("busy", ifc.busy, e_busy);
            chk("done", ifc.done, cyc == m_done_cyc);
            chk("buf_rotate", ifc.buf_rotate, e_rot);
            chk("ld_start", ifc.ld_start, e_la);
            chk("cp_start", ifc.cp_start, e_ca);
            chk("st_start", ifc.st_start, e_sa);
            if (e_la) chk("ld_tile_idx", ifc.ld_tile_idx, m_phase % (1 << TILE_W));
            if (e_ca) chk("cp_tile_idx", ifc.cp_tile_idx, (m_phase - 1) % (1 << TILE_W));
            if (e_sa) chk("st_tile_idx", ifc.st_tile_idx, (m_phase - 2) % (1 << TILE_W));
            if (ifc.abort) begin
                if (m_busy_to > cyc) m_busy_to = cyc;
                m_rot_cyc  = -1;
                m_done_cyc = -1;
                m_wait     = 1'b0;
            end else if (ifc.start && !e_busy) begin
                m_N         = int'(ifc.num_tiles);
                m_phase     = 0;
                m_busy_from = cyc + 1;
                if (m_N == 0) begin
                    m_busy_to  = cyc + 1;
                    m_done_cyc = cyc + 2;
                end else begin
                    m_busy_to = 1 << 30;
                    m_rot_cyc = cyc + 1;
                end
            end else if (e_rot) begin
                m_need_ld = e_la;
                m_need_cp = e_ca;
                m_need_st = e_sa;
                m_wait    = 1'b1;
            end else if (m_wait) begin
                if (ifc.ld_done) m_need_ld = 1'b0;
                if (ifc.cp_done) m_need_cp = 1'b0;
                if (ifc.st_done) m_need_st = 1'b0;
                if (!m_need_ld && !m_need_cp && !m_need_st) begin
                    m_wait = 1'b0;
                    if (m_phase == m_N + 1) begin
                        m_busy_to  = cyc + 2;
                        m_done_cyc = cyc + 3;
                    end else begin
                        m_phase   = m_phase + 1;
                        m_rot_cyc = cyc + 2;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (ifc.buf_rotate) cnt_rot++;
            if (ifc.ld_start) begin cnt_ld++; ld_q.push_back(int'(ifc.ld_tile_idx)); end
            if (ifc.cp_start) begin cnt_cp++; cp_q.push_back(int'(ifc.cp_tile_idx)); end
            if (ifc.st_start) begin cnt_st++; st_q.push_back(int'(ifc.st_tile_idx)); end
            if (ifc.done) begin cnt_done++; last_done_cyc = cyc; end
            if (ifc.busy) cnt_busy++;
        end
    end

    // unit responders: done pulse a fixed number of cycles after each start
    initial forever begin
        @(negedge clk);
        if (resp_en && rstn && ifc.ld_start) fork
            begin
                automatic int d = ld_lat;
                repeat (d) @(posedge clk);
                #1 ifc.ld_done = 1'b1;
                @(posedge clk);
                #1 ifc.ld_done = 1'b0;
            end
        join_none
    end
    initial forever begin
        @(negedge clk);
        if (resp_en && rstn && ifc.cp_start) fork
            begin
                automatic int d = cp_lat + ((ifc.cp_tile_idx == '0) ? cp_extra : 0);
                repeat (d) @(posedge clk);
                #1 ifc.cp_done = 1'b1;
                @(posedge clk);
                #1 ifc.cp_done = 1'b0;
            end
        join_none
    end
    initial forever begin
        @(negedge clk);
        if (resp_en && rstn && ifc.st_start) fork
            begin
                automatic int d = st_lat;
                repeat (d) @(posedge clk);
                #1 ifc.st_done = 1'b1;
                @(posedge clk);
                #1 ifc.st_done = 1'b0;
            end
        join_none
    end

    task automatic start_layer(input int n, output int s);
        ifc.num_tiles = n[TILE_W-1:0];
        ifc.start     = 1'b1;
        s             = cyc;
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int lim, input string name);
        int k = 0;
        while (cnt_done == d0 && k < lim) begin
            tick();
            k++;
        end
        chk({name, "_done_count"}, cnt_done - d0, 1);
        tick();
    endtask

    task automatic pulse_at(input int c, input bit l, input bit p, input bit t);
        while (cyc < c) tick();
        ifc.ld_done = l;
        ifc.cp_done = p;
        ifc.st_done = t;
        tick();
        ifc.ld_done = 1'b0;
        ifc.cp_done = 1'b0;
        ifc.st_done = 1'b0;
    endtask

    initial begin
        int s, r0, l0, c0, t0, d0, b0;
        ifc.start = 1'b0; ifc.abort = 1'b0; ifc.num_tiles = '0;
        ifc.ld_done = 1'b0; ifc.cp_done = 1'b0; ifc.st_done = 1'b0;
        repeat (2) tick();
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_rotate", ifc.buf_rotate, 0);
        chk("rst_ld_start", ifc.ld_start, 0);
        chk("rst_ld_idx", ifc.ld_tile_idx, 0);
        rstn = 1'b1;
        tick();
        chk_en  = 1'b1;
        resp_en = 1'b1;

        // N=3, all units answer 4 cycles after start
        r0 = cnt_rot; l0 = cnt_ld; c0 = cnt_cp; t0 = cnt_st; d0 = cnt_done;
        ld_q.delete(); cp_q.delete(); st_q.delete();
        start_layer(3, s);
        wait_done(d0, 200, "t1");
        chk("t1_latency", last_done_cyc - s, 32);
        chk("t1_rotates", cnt_rot - r0, 5);
        chk("t1_ld_cnt", cnt_ld - l0, 3);
        chk("t1_cp_cnt", cnt_cp - c0, 3);
        chk("t1_st_cnt", cnt_st - t0, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_ld_idx", (i < ld_q.size()) ? ld_q[i] : -1, i);
            chk("t1_cp_idx", (i < cp_q.size()) ? cp_q[i] : -1, i);
            chk("t1_st_idx", (i < st_q.size()) ? st_q[i] : -1, i);
        end

        // N=0
        r0 = cnt_rot; l0 = cnt_ld; d0 = cnt_done; b0 = cnt_busy;
        start_layer(0, s);
        wait_done(d0, 20, "t2");
        chk("t2_latency", last_done_cyc - s, 2);
        chk("t2_rotates", cnt_rot - r0, 0);
        chk("t2_ld_cnt", cnt_ld - l0, 0);
        chk("t2_busy_cycles", cnt_busy - b0, 1);

        // N=2, compute of tile 0 is 10 cycles late
        cp_extra = 10;
        r0 = cnt_rot; d0 = cnt_done;
        start_layer(2, s);
        wait_done(d0, 200, "t3");
        chk("t3_latency", last_done_cyc - s, 36);
        chk("t3_rotates", cnt_rot - r0, 4);
        cp_extra = 0;

        // N=2 with stray, early and repeated done pulses
        resp_en = 1'b0;
        tick();
        r0 = cnt_rot; d0 = cnt_done;
        start_layer(2, s);
        pulse_at(s + 1, 1'b1, 1'b0, 1'b1);
        pulse_at(s + 2, 1'b0, 1'b0, 1'b1);
        pulse_at(s + 6, 1'b1, 1'b0, 1'b0);
        pulse_at(s + 10, 1'b0, 1'b1, 1'b0);
        pulse_at(s + 11, 1'b0, 1'b1, 1'b0);
        pulse_at(s + 14, 1'b1, 1'b0, 1'b0);
        chk("t4_held", cnt_rot - r0, 2);
        pulse_at(s + 18, 1'b0, 1'b1, 1'b1);
        pulse_at(s + 22, 1'b0, 1'b0, 1'b1);
        wait_done(d0, 50, "t4");
        chk("t4_latency", last_done_cyc - s, 25);
        chk("t4_rotates", cnt_rot - r0, 4);
        resp_en = 1'b1;

        // N=4 aborted in phase 2 wait, then a clean N=1 layer
        r0 = cnt_rot; d0 = cnt_done;
        start_layer(4, s);
        while (cyc < s + 15) tick();
        ifc.abort = 1'b1;
        tick();
        ifc.abort = 1'b0;
        chk("t5_busy_after_abort", ifc.busy, 0);
        repeat (15) tick();
        chk("t5_no_done", cnt_done - d0, 0);
        chk("t5_rotates", cnt_rot - r0, 3);
        r0 = cnt_rot; l0 = cnt_ld; c0 = cnt_cp; t0 = cnt_st; d0 = cnt_done;
        start_layer(1, s);
        wait_done(d0, 100, "t5b");
        chk("t5b_latency", last_done_cyc - s, 20);
        chk("t5b_rotates", cnt_rot - r0, 3);
        chk("t5b_starts", (cnt_ld - l0) * 100 + (cnt_cp - c0) * 10 + (cnt_st - t0), 111);

        // start with num_tiles=7 while busy must be ignored
        r0 = cnt_rot; d0 = cnt_done;
        start_layer(2, s);
        repeat (3) tick();
        ifc.num_tiles = 8'd7;
        ifc.start     = 1'b1;
        tick();
        ifc.start = 1'b0;
        wait_done(d0, 200, "t6");
        chk("t6_latency", last_done_cyc - s, 26);
        chk("t6_rotates", cnt_rot - r0, 4);

        // asynchronous reset in the middle of phase 1
        start_layer(3, s);
        while (cyc < s + 9) tick();
        chk_en  = 1'b0;
        resp_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_busy", ifc.busy, 0);
        chk("t6_rst_ld_idx", ifc.ld_tile_idx, 0);
        chk("t6_rst_cp_idx", ifc.cp_tile_idx, 0);
        chk("t6_rst_outs", {ifc.done, ifc.buf_rotate, ifc.ld_start, ifc.cp_start, ifc.st_start}, 0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("t6_idle_after_rst", {ifc.busy, ifc.buf_rotate}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
